// File: rtl/reg_exec_unit.sv
// Multi-cycle execute/writeback stage: reads rs/rt from the register file, runs a
// single-cycle ALU op or a 32-step shift-add multiply, then issues one write strobe.
module reg_exec_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       Instr,
  output logic [ADDR_W-1:0] Read_Reg_Num_1,
  output logic [ADDR_W-1:0] Read_Reg_Num_2,
  input  logic [DATA_W-1:0] Read_Data_1,
  input  logic [DATA_W-1:0] Read_Data_2,
  output logic [ADDR_W-1:0] Write_Reg_Num_1,
  output logic [DATA_W-1:0] Write_Data,
  output logic              RegWrite,
  output logic              busy,
  output logic              illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_SRA = 6'h03;
  localparam logic [5:0] F_MUL = 6'h18;

  state_t              state_r;
  logic [5:0]          opcode_r;
  logic [ADDR_W-1:0]   rd_r;
  logic [4:0]          shamt_r;
  logic [5:0]          funct_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   acc_r;
  logic [4:0]          cnt_r;

  logic                legal_s;
  logic                is_mul_s;
  logic [DATA_W-1:0]   alu_s;
  logic [DATA_W-1:0]   mul_step_s;
  logic [DATA_W-1:0]   acc_next_s;

  // Legal means opcode zero and a funct from the supported set.
  function automatic logic funct_known(input logic [5:0] funct);
    case (funct)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR,
      F_SLT, F_SLL, F_SRL, F_SRA, F_MUL: funct_known = 1'b1;
      default:                           funct_known = 1'b0;
    endcase
  endfunction

  assign legal_s     = (opcode_r == 6'd0) && funct_known(funct_r);
  assign is_mul_s    = legal_s && (funct_r == F_MUL);
  assign instr_ready = (state_r == IDLE) && Reset;
  assign busy        = (state_r != IDLE);

  // Single-cycle ALU on the latched operands.
  always_comb begin
    alu_s = '0;
    case (funct_r)
      F_ADD:   alu_s = a_r + b_r;
      F_SUB:   alu_s = a_r - b_r;
      F_AND:   alu_s = a_r & b_r;
      F_OR:    alu_s = a_r | b_r;
      F_XOR:   alu_s = a_r ^ b_r;
      F_NOR:   alu_s = ~(a_r | b_r);
      F_SLT:   alu_s = {{(DATA_W-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      F_SLL:   alu_s = b_r << shamt_r;
      F_SRL:   alu_s = b_r >> shamt_r;
      F_SRA:   alu_s = DATA_W'($signed(b_r) >>> shamt_r);
      default: alu_s = '0;
    endcase
  end

  // One shift-add step of the multiplier, indexed by the iteration count.
  always_comb begin
    if (b_r[cnt_r]) begin
      mul_step_s = a_r << cnt_r;
    end else begin
      mul_step_s = '0;
    end
    acc_next_s = acc_r + mul_step_s;
  end

  // Control FSM with registered register-file and status outputs.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_r         <= IDLE;
      opcode_r        <= 6'd0;
      rd_r            <= '0;
      shamt_r         <= 5'd0;
      funct_r         <= 6'd0;
      a_r             <= '0;
      b_r             <= '0;
      acc_r           <= '0;
      cnt_r           <= 5'd0;
      Read_Reg_Num_1  <= '0;
      Read_Reg_Num_2  <= '0;
      Write_Reg_Num_1 <= '0;
      Write_Data      <= '0;
      RegWrite        <= 1'b0;
      illegal         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          RegWrite <= 1'b0;
          illegal  <= 1'b0;
          if (instr_valid) begin
            opcode_r       <= Instr[31:26];
            Read_Reg_Num_1 <= Instr[25:21];
            Read_Reg_Num_2 <= Instr[20:16];
            rd_r           <= Instr[15:11];
            shamt_r        <= Instr[10:6];
            funct_r        <= Instr[5:0];
            state_r        <= READ;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          a_r     <= Read_Data_1;
          b_r     <= Read_Data_2;
          acc_r   <= '0;
          cnt_r   <= 5'd0;
          state_r <= EXEC;
        end
        EXEC: begin
          // MUL stays here for iterations 0..30; iteration 31 folds into the result.
          if (is_mul_s && (cnt_r != 5'd31)) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + 5'd1;
          end else begin
            state_r         <= WB;
            Write_Reg_Num_1 <= rd_r;
            if (legal_s) begin
              Write_Data <= is_mul_s ? acc_next_s : alu_s;
            end else begin
              Write_Data <= Write_Data;
            end
            RegWrite <= legal_s && (rd_r != '0);
            illegal  <= !legal_s;
          end
        end
        WB: begin
          RegWrite <= 1'b0;
          illegal  <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          RegWrite <= 1'b0;
          illegal  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_exec_unit.sv
// Self-checking bench for reg_exec_unit: directed cases plus randomized instructions
// checked against a behavioural model and a simple register file.
module tb_reg_exec_unit;

  logic        clk;
  logic        Reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [4:0]  Read_Reg_Num_1;
  logic [4:0]  Read_Reg_Num_2;
  logic [31:0] Read_Data_1;
  logic [31:0] Read_Data_2;
  logic [4:0]  Write_Reg_Num_1;
  logic [31:0] Write_Data;
  logic        RegWrite;
  logic        busy;
  logic        illegal;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wd_model = 32'd0;

  // Register file model: combinational reads, write on RegWrite, plus a preload port.
  logic [31:0] regs [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [31:0] pl_val = 32'd0;

  assign Read_Data_1 = (Read_Reg_Num_1 == 5'd0) ? 32'd0 : regs[Read_Reg_Num_1];
  assign Read_Data_2 = (Read_Reg_Num_2 == 5'd0) ? 32'd0 : regs[Read_Reg_Num_2];

  always_ff @(posedge clk) begin
    if (pl_en) regs[pl_idx] <= pl_val;
    else if (RegWrite && Write_Reg_Num_1 != 5'd0) regs[Write_Reg_Num_1] <= Write_Data;
  end

  reg_exec_unit #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .Instr(Instr), .Read_Reg_Num_1(Read_Reg_Num_1), .Read_Reg_Num_2(Read_Reg_Num_2),
    .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2),
    .Write_Reg_Num_1(Write_Reg_Num_1), .Write_Data(Write_Data),
    .RegWrite(RegWrite), .busy(busy), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rs, input int rt,
                                     input int rd, input int sh, input int fn);
    mk = {op[5:0], rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  // Reference semantics of each instruction in plain arithmetic.
  function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] res,
                                    output logic legal, output logic mul);
    int sh;
    sh = int'(ins[10:6]);
    legal = 1'b1;
    mul = 1'b0;
    res = 32'd0;
    case (ins[5:0])
      6'h20: res = a + b;
      6'h22: res = a - b;
      6'h24: res = a & b;
      6'h25: res = a | b;
      6'h26: res = a ^ b;
      6'h27: res = ~(a | b);
      6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00: res = b << sh;
      6'h02: res = b >> sh;
      6'h03: res = 32'($signed(b) >>> sh);
      6'h18: begin res = 32'(64'(a) * 64'(b)); mul = 1'b1; end
      default: legal = 1'b0;
    endcase
    if (ins[31:26] != 6'd0) legal = 1'b0;
    mul = mul & legal;
  endfunction

  task automatic set_reg(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx[4:0]; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one instruction and check read ports, write timing, data and pulse counts.
  task automatic run_instr(input logic [31:0] ins, input string tag);
    logic [31:0] a, b, exp;
    logic legal, mul, exp_rw;
    int lat, rw_n, il_n, busy_n;
    a = (ins[25:21] == 5'd0) ? 32'd0 : regs[ins[25:21]];
    b = (ins[20:16] == 5'd0) ? 32'd0 : regs[ins[20:16]];
    ref_model(ins, a, b, exp, legal, mul);
    exp_rw = legal && (ins[15:11] != 5'd0);
    lat = mul ? 33 : 2;
    for (int i = 0; i < 50 && !instr_ready; i++) @(negedge clk);
    check_val({tag, "_ready"}, 32'(instr_ready), 32'd1);
    Instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check_val({tag, "_rs"}, 32'(Read_Reg_Num_1), 32'(ins[25:21]));
    check_val({tag, "_rt"}, 32'(Read_Reg_Num_2), 32'(ins[20:16]));
    busy_n = busy ? 1 : 0;
    rw_n = 0;
    il_n = 0;
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      rw_n += RegWrite ? 1 : 0;
      il_n += illegal ? 1 : 0;
      busy_n += busy ? 1 : 0;
      if (i == lat) begin
        check_val({tag, "_regwrite"}, 32'(RegWrite), 32'(exp_rw));
        check_val({tag, "_illegal"}, 32'(illegal), 32'(!legal));
        check_val({tag, "_wrnum"}, 32'(Write_Reg_Num_1), 32'(ins[15:11]));
        if (legal) wd_model = exp;
        check_val({tag, "_wdata"}, Write_Data, wd_model);
      end
    end
    check_val({tag, "_rw_pulses"}, 32'(rw_n), 32'(exp_rw));
    check_val({tag, "_il_pulses"}, 32'(il_n), 32'(!legal));
    check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat + 1));
    check_val({tag, "_idle_ready"}, 32'(instr_ready), 32'd1);
  endtask

  logic [5:0] fn_tab [0:11];
  int rw_seen;

  initial begin
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24;  fn_tab[3] = 6'h25;
    fn_tab[4] = 6'h26; fn_tab[5] = 6'h27; fn_tab[6] = 6'h2A;  fn_tab[7] = 6'h00;
    fn_tab[8] = 6'h02; fn_tab[9] = 6'h03; fn_tab[10] = 6'h18; fn_tab[11] = 6'h3F;

    // Reset with a valid instruction offered: nothing may be captured.
    Reset = 1'b0;
    instr_valid = 1'b1;
    Instr = mk(0, 1, 2, 3, 0, 32'h20);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready_low", 32'(instr_ready), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rr1", 32'(Read_Reg_Num_1), 32'd0);
    Reset = 1'b1;
    instr_valid = 1'b0;
    #1;
    check_val("rst_ready", 32'(instr_ready), 32'd1);
    check_val("rst_outs", {Write_Data[23:0], Write_Reg_Num_1, Read_Reg_Num_2,
                           RegWrite, illegal}, 32'd0);
    check_val("rst_wdata", Write_Data, 32'd0);

    // Directed arithmetic cases.
    set_reg(1, 32'd20);
    set_reg(2, 32'd30);
    run_instr(mk(0, 1, 2, 3, 0, 32'h20), "add");
    check_val("add_const", Write_Data, 32'd50);
    set_reg(1, 32'hFFFF_FFFE);
    set_reg(2, 32'd3);
    run_instr(mk(0, 1, 2, 7, 0, 32'h22), "sub");
    check_val("sub_const", Write_Data, 32'hFFFF_FFFB);
    run_instr(mk(0, 1, 2, 4, 0, 32'h2A), "slt");
    check_val("slt_const", Write_Data, 32'd1);
    run_instr(mk(0, 0, 1, 5, 1, 32'h03), "sra");
    check_val("sra_const", Write_Data, 32'hFFFF_FFFF);
    run_instr(mk(0, 0, 1, 8, 1, 32'h02), "srl");
    check_val("srl_const", Write_Data, 32'h7FFF_FFFF);
    set_reg(1, 32'd7);
    set_reg(2, 32'h1000_0001);
    run_instr(mk(0, 1, 2, 6, 0, 32'h18), "mul");
    check_val("mul_const", Write_Data, 32'h7000_0007);
    run_instr(mk(0, 1, 2, 0, 0, 32'h20), "add_rd0");
    run_instr(mk(32'h23, 1, 2, 9, 0, 32'h20), "bad_op");
    run_instr(mk(0, 1, 2, 9, 0, 32'h3F), "bad_fn");

    // Back-to-back with valid held high: SUB must see the freshly written r3.
    set_reg(1, 32'd20);
    set_reg(2, 32'd30);
    @(negedge clk);
    Instr = mk(0, 1, 2, 3, 0, 32'h20);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Instr = mk(0, 3, 1, 7, 0, 32'h22);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 2) check_val("b2b_add_wd", Write_Data, 32'd50);
      if (i == 3) check_val("b2b_ready", 32'(instr_ready), 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check_val("b2b_sub_rs", 32'(Read_Reg_Num_1), 32'd3);
    check_val("b2b_sub_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    check_val("b2b_sub_rw", 32'(RegWrite), 32'd1);
    check_val("b2b_sub_wd", Write_Data, 32'd30);
    wd_model = 32'd30;
    @(negedge clk);

    // Reset in the middle of a multiply (iteration 10).
    set_reg(1, 32'd7);
    set_reg(2, 32'h1000_0001);
    @(negedge clk);
    Instr = mk(0, 1, 2, 6, 0, 32'h18);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (11) @(negedge clk);
    Reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    #1;
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_ready", 32'(instr_ready), 32'd1);
    check_val("mrst_rw", 32'(RegWrite), 32'd0);
    check_val("mrst_wd", Write_Data, 32'd0);
    wd_model = 32'd0;
    rw_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rw_seen += RegWrite ? 1 : 0;
    end
    check_val("mrst_no_write", 32'(rw_seen), 32'd0);

    // Randomized instructions against the reference model.
    for (int r = 1; r < 8; r++) set_reg(r, $urandom);
    set_reg(7, 32'h8000_0000);
    for (int n = 0; n < 30; n++) begin
      int op, fi;
      op = ($urandom_range(0, 9) == 0) ? 32'h23 : 0;
      fi = $urandom_range(0, 11);
      run_instr(mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 31), 32'(fn_tab[fi])), $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
